spi_tx_sched: RTL
=================

SPI_TX_SCHED -- requirements
Module: spi_tx_sched

Interface
REQ-001 Parameter NSRC, default 4: number of sensor requesters.
REQ-002 Parameter DW, default 40: payload width per requester, equal to the SPI slave transmit shift width.
REQ-003 Parameter TIMEOUT_CYC, default 100000: clk cycles allowed per active frame; used only under SPI_TX_SCHED_TIMEOUT_EN.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 src_valid  in  NSRC  per-source request; data pending.
REQ-007 src_data  in  NSRC*DW  per-source payload; source i occupies bits [i*DW +: DW].
REQ-008 src_ack  out  NSRC  one-cycle pulse: the source's payload was fully shifted out.
REQ-009 ssel_start  in  1  one-cycle pulse from the SPI slave at frame start (SSEL falling edge).
REQ-010 ssel_end  in  1  one-cycle pulse from the SPI slave at frame end (SSEL rising edge).
REQ-011 bit_cnt  in  7  SCK rising edges counted in the current frame.
REQ-012 tx_data  out  DW  word the SPI slave loads on ssel_start.
REQ-013 tx_valid  out  1  high when tx_data holds a real source payload.
REQ-014 tx_tag  out  $clog2(NSRC)  index of the owning source; 0 when tx_valid is 0.
REQ-015 frame_ok  out  1  one-cycle pulse: a valid frame completed.
REQ-016 frame_err  out  1  one-cycle pulse: a valid frame was aborted (short frame or timeout).

Function
REQ-017 The FSM SHALL have the states IDLE, READY, BUSY and NULLF.
REQ-018 IDLE, no ssel_start, any src_valid: the round-robin arbiter grants one source, tx_data/tx_tag latch it, tx_valid=1, next state READY; one cycle of latency.
REQ-019 Round-robin: search starts at (last acked index + 1) mod NSRC; after reset it starts at index 0.
REQ-020 IDLE with ssel_start (with or without src_valid): tx_data=0, tx_valid=0, next state NULLF; ssel_start takes priority over arbitration.
REQ-021 NULLF: on ssel_end, return to IDLE; no ack, no frame_ok, no frame_err.
REQ-022 READY: on ssel_start, go to BUSY; tx_data is held unchanged.
REQ-023 In READY and BUSY, tx_data, tx_tag and tx_valid SHALL not change, even if the owner drops src_valid or changes src_data.
REQ-024 BUSY with ssel_end and bit_cnt>=DW: pulse src_ack[tx_tag] and frame_ok in the next cycle, update the round-robin pointer, clear tx_valid, go to IDLE.
REQ-025 BUSY with ssel_end and bit_cnt<DW: pulse frame_err, keep the buffer, return to READY (same word retransmitted); no ack.
REQ-026 ssel_end in IDLE or READY, and ssel_start in BUSY or NULLF, SHALL be ignored.
REQ-027 At most one src_ack bit SHALL be high in any cycle; frame_ok and frame_err SHALL be mutually exclusive.
REQ-028 bit_cnt SHALL be compared unsigned; values above DW count as complete.

Reset
REQ-029 rst SHALL force IDLE, tx_data=0, tx_valid=0, tx_tag=0, src_ack=0, frame_ok=0, frame_err=0, round-robin pointer to 0, timeout counter to 0.
REQ-030 rst mid-frame (BUSY) SHALL discard the buffer without ack; the source's src_valid stays pending and is re-arbitrated.

Configuration
REQ-031 With SPI_TX_SCHED_TIMEOUT_EN defined: a counter runs in BUSY and NULLF; reaching TIMEOUT_CYC without ssel_end aborts the frame.
REQ-032 Timeout abort from BUSY: pulse frame_err and go to READY. Timeout abort from NULLF: go to IDLE silently.
REQ-033 Without SPI_TX_SCHED_TIMEOUT_EN: no counter logic is generated, and BUSY/NULLF wait indefinitely.

Structure
REQ-034 Package spi_tx_sched_pkg SHALL hold the state enum, the default NSRC/DW constants and the null word constant (all zeros).
REQ-035 Round-robin selection SHALL be the sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index).

Verification
REQ-036 Reset, then src_valid=4'b0100, src_data[2]=40'hF555555555 -> 1 cycle later tx_valid=1, tx_tag=2, tx_data=40'hF555555555.
REQ-037 READY (tag 2); ssel_start; bit_cnt=40; ssel_end -> src_ack=4'b0100 and frame_ok pulse; state IDLE.
REQ-038 All four sources valid, four full frames -> grant order 0,1,2,3; then after ack of 3, next grant 0.
REQ-039 Valid word loaded; frame ends with bit_cnt=12 -> frame_err pulse, no ack, same tx_data re-presented; next 88-bit frame -> ack.
REQ-040 ssel_start in IDLE with src_valid=4'b0001 in the same cycle -> NULLF, tx_valid=0, tx_data=0; after ssel_end, source 0 is granted next.
REQ-041 With SPI_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=50: ssel_start, no ssel_end for 50 cycles -> frame_err, state READY; rst asserted in BUSY -> IDLE, no ack.

Source files
------------

// File: rtl/spi_tx_sched_pkg.sv
// Shared types and constants for the SPI transmit scheduler.
// Default sizes, FSM state encoding, the null word, and a tag-width helper.
package spi_tx_sched_pkg;

    localparam int unsigned DefNsrc = 4;
    localparam int unsigned DefDw   = 40;

    // Word presented to the SPI slave when no source owns the frame.
    localparam logic [DefDw-1:0] NullWord = '0;

    typedef enum logic [1:0] {
        StIdle,
        StReady,
        StBusy,
        StNullf
    } state_e;

    // Width of a source index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_tx_sched_if.sv
// Bundle of the requester-side and SPI-slave-side signals of the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface spi_tx_sched_if #(
    parameter int unsigned NSRC = spi_tx_sched_pkg::DefNsrc,
    parameter int unsigned DW   = spi_tx_sched_pkg::DefDw
);
    localparam int unsigned TW = spi_tx_sched_pkg::idx_width(NSRC);

    logic [NSRC-1:0]    src_valid;
    logic [NSRC*DW-1:0] src_data;
    logic [NSRC-1:0]    src_ack;
    logic               ssel_start;
    logic               ssel_end;
    logic [6:0]         bit_cnt;
    logic [DW-1:0]      tx_data;
    logic               tx_valid;
    logic [TW-1:0]      tx_tag;
    logic               frame_ok;
    logic               frame_err;

    modport slave (
        input  src_valid, src_data, ssel_start, ssel_end, bit_cnt,
        output src_ack, tx_data, tx_valid, tx_tag, frame_ok, frame_err
    );

    modport master (
        output src_valid, src_data, ssel_start, ssel_end, bit_cnt,
        input  src_ack, tx_data, tx_valid, tx_tag, frame_ok, frame_err
    );

endinterface

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Rotating priority search starting from ptr.
    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_tx_sched.sv
// SPI transmit scheduler: arbitrates NSRC requesters round-robin, holds the
// granted payload stable for the SPI slave across a frame, and acks the
// owner only after a complete frame. Short frames are retried with the same
// word. Optional frame timeout: define SPI_TX_SCHED_TIMEOUT_EN.
module spi_tx_sched
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned NSRC        = DefNsrc,
    parameter int unsigned DW          = DefDw,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic           clk,
    input logic           rst,
    spi_tx_sched_if.slave bus
);

    localparam int unsigned TW = idx_width(NSRC);

    state_e          state_q, state_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [TW-1:0]   tx_tag_q, tx_tag_d;
    logic [NSRC-1:0] ack_q, ack_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [TW-1:0]   ptr_q, ptr_d;

    logic [NSRC-1:0] gnt;
    logic [TW-1:0]   gnt_idx;
    logic [DW-1:0]   gnt_data;
    logic            full_frame;
    logic            tmo_hit;

    rr_arbiter #(
        .N  (NSRC),
        .IW (TW)
    ) u_arb (
        .req   (bus.src_valid),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // Payload of the granted source and unsigned frame-length check.
    always_comb begin
        gnt_data   = bus.src_data[32'(gnt_idx) * DW +: DW];
        full_frame = ({25'd0, bus.bit_cnt} >= DW);
    end

`ifdef SPI_TX_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            in_frame;

    // Count cycles spent in an open frame; cleared whenever a frame is not open.
    always_comb begin
        in_frame  = (state_q == StBusy) || (state_q == StNullf);
        tmo_hit   = in_frame && !bus.ssel_end && (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));
        tmo_cnt_d = (in_frame && !bus.ssel_end && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;

    // TIMEOUT_CYC only has an effect in the timeout build.
    if (TIMEOUT_CYC == 0) begin : g_tmo_unused
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_tag_d   = tx_tag_q;
        ack_d      = '0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        ptr_d      = ptr_q;

        unique case (state_q)
            StIdle: begin
                // A frame already starting wins over arbitration: send null.
                if (bus.ssel_start) begin
                    tx_data_d  = DW'(NullWord);
                    tx_valid_d = 1'b0;
                    tx_tag_d   = '0;
                    state_d    = StNullf;
                end else if (|gnt) begin
                    tx_data_d  = gnt_data;
                    tx_valid_d = 1'b1;
                    tx_tag_d   = gnt_idx;
                    state_d    = StReady;
                end
            end
            StReady: begin
                if (bus.ssel_start) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus.ssel_end) begin
                    if (full_frame) begin
                        ack_d[tx_tag_d] = 1'b1;
                        ok_d            = 1'b1;
                        ptr_d           = (32'(tx_tag_q) == NSRC - 1) ? '0 : tx_tag_q + 1'b1;
                        tx_data_d       = DW'(NullWord);
                        tx_valid_d      = 1'b0;
                        tx_tag_d        = '0;
                        state_d         = StIdle;
                    end else begin
                        // Short frame: keep the word so it is sent again.
                        err_d   = 1'b1;
                        state_d = StReady;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StReady;
                end
            end
            StNullf: begin
                if (bus.ssel_end || tmo_hit) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_tag_q   <= '0;
            ack_q      <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_tag_q   <= tx_tag_d;
            ack_q      <= ack_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_tag    = tx_tag_q;
    assign bus.src_ack   = ack_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;

endmodule
